// File: rtl/irq_coalesce_arbiter.sv
// Event coalescing front end: per-source pending counters and age timers feed a
// round-robin one-hot grant. Define IRQ_COAL_ACK_WDOG_EN to add the ack watchdog.
module irq_coalesce_arbiter #(
    parameter int NUM_SRC     = 8,
    parameter int CNT_W       = 8,
    parameter int TMR_W       = 16,
    parameter int HOLDOFF_CYC = 4,
    parameter int ACK_TO_CYC  = 1024
) (
    input  logic               clk,
    input  logic               srst,
    input  logic [NUM_SRC-1:0] src_event,
    input  logic [NUM_SRC-1:0] cfg_enable,
    input  logic [CNT_W-1:0]   cfg_threshold,
    input  logic [TMR_W-1:0]   cfg_timeout,
    input  logic               irq_ack,
    output logic [31:0]        irq_vector,
    output logic [4:0]         irq_src_id,
    output logic [CNT_W-1:0]   irq_event_count,
    output logic               busy,
    output logic               ack_timeout_err
);

    localparam int HO_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
    localparam logic [HO_W-1:0] HO_LOAD = HO_W'((HOLDOFF_CYC > 0) ? HOLDOFF_CYC - 1 : 0);

    if (NUM_SRC < 1 || NUM_SRC > 32 || HOLDOFF_CYC < 0 || ACK_TO_CYC < 1) begin : g_param_check
        $error("irq_coalesce_arbiter: illegal parameter value");
    end

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_HOLDOFF  = 2'd2
    } state_t;

    logic [CNT_W-1:0]   cnt_q [NUM_SRC];
    logic [CNT_W-1:0]   cnt_d [NUM_SRC];
    logic [TMR_W-1:0]   age_q [NUM_SRC];
    logic [TMR_W-1:0]   age_d [NUM_SRC];
    logic [NUM_SRC-1:0] ready;
    logic [NUM_SRC-1:0] grant;
    logic [CNT_W-1:0]   thr_eff;

    logic               sel_found;
    logic [4:0]         sel_idx;
    logic [CNT_W-1:0]   sel_cnt;

    state_t             state_q;
    logic [4:0]         ptr_q;
    logic [HO_W-1:0]    hold_q;
    logic [31:0]        vec_q;
    logic [4:0]         id_q;
    logic [CNT_W-1:0]   snap_q;
    logic               wd_expire;

    // A threshold of zero behaves as one so a single event can trigger.
    always_comb begin
        thr_eff = (cfg_threshold == '0) ? CNT_W'(1) : cfg_threshold;
        for (int i = 0; i < NUM_SRC; i++) begin
            ready[i] = cfg_enable[i] && (cnt_q[i] != '0) &&
                       ((cnt_q[i] >= thr_eff) ||
                        ((cfg_timeout != '0) && (age_q[i] >= cfg_timeout)));
        end
    end

    // Round-robin: search indices above the pointer first, then wrap to the low ones.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_cnt   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!sel_found && ready[i] && (i > int'(ptr_q))) begin
                sel_found = 1'b1;
                sel_idx   = 5'(i);
                sel_cnt   = cnt_q[i];
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!sel_found && ready[i] && (i <= int'(ptr_q))) begin
                sel_found = 1'b1;
                sel_idx   = 5'(i);
                sel_cnt   = cnt_q[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            grant[i] = (state_q == S_IDLE) && sel_found && (sel_idx == 5'(i));
        end
    end

    // A grant hands the whole count to the snapshot; a same-cycle event starts the next batch.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            cnt_d[i] = cnt_q[i];
            age_d[i] = age_q[i];
            if (!cfg_enable[i]) begin
                cnt_d[i] = '0;
                age_d[i] = '0;
            end else begin
                if (grant[i]) begin
                    cnt_d[i] = CNT_W'(src_event[i]);
                end else if (src_event[i] && (cnt_q[i] != '1)) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
                if (grant[i] || (cnt_q[i] == '0)) begin
                    age_d[i] = '0;
                end else if (age_q[i] != '1) begin
                    age_d[i] = age_q[i] + TMR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_q[i] <= cnt_d[i];
                age_q[i] <= age_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= S_IDLE;
            ptr_q   <= 5'(NUM_SRC - 1);
            hold_q  <= '0;
            vec_q   <= '0;
            id_q    <= '0;
            snap_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sel_found) begin
                        state_q <= S_WAIT_ACK;
                        ptr_q   <= sel_idx;
                        vec_q   <= 32'd1 << sel_idx;
                        id_q    <= sel_idx;
                        snap_q  <= sel_cnt;
                    end
                end
                S_WAIT_ACK: begin
                    // Ack and watchdog expiry share the release path; the error flag lives in the watchdog.
                    if (irq_ack || wd_expire) begin
                        vec_q  <= '0;
                        id_q   <= '0;
                        snap_q <= '0;
                        if (HOLDOFF_CYC == 0) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_HOLDOFF;
                            hold_q  <= HO_LOAD;
                        end
                    end
                end
                S_HOLDOFF: begin
                    if (hold_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        hold_q <= hold_q - HO_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef IRQ_COAL_ACK_WDOG_EN
    localparam int WD_W = $clog2(ACK_TO_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(ACK_TO_CYC - 1);

    logic [WD_W-1:0] wd_q;
    logic            err_q;

    assign wd_expire = (state_q == S_WAIT_ACK) && !irq_ack && (wd_q == WD_LAST);

    always_ff @(posedge clk) begin
        if (srst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q != S_WAIT_ACK) begin
                wd_q <= '0;
            end else if (!wd_expire) begin
                wd_q <= wd_q + WD_W'(1);
            end
            if (wd_expire) begin
                err_q <= 1'b1;
            end
        end
    end

    assign ack_timeout_err = err_q;
`else
    assign wd_expire       = 1'b0;
    assign ack_timeout_err = 1'b0;
`endif

    assign irq_vector      = vec_q;
    assign irq_src_id      = id_q;
    assign irq_event_count = snap_q;
    assign busy            = (state_q == S_WAIT_ACK) || (state_q == S_HOLDOFF);

endmodule

// File: tb/tb_irq_coalesce_arbiter.sv
// Directed bench for irq_coalesce_arbiter: vector table plus multi-cycle sequences.
module tb_irq_coalesce_arbiter;

    logic        clk = 1'b0;
    logic        srst;
    logic [7:0]  src_event;
    logic [7:0]  cfg_enable;
    logic [7:0]  cfg_threshold;
    logic [15:0] cfg_timeout;
    logic        irq_ack;
    logic [31:0] irq_vector;
    logic [4:0]  irq_src_id;
    logic [7:0]  irq_event_count;
    logic        busy;
    logic        ack_timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  ev;
        logic [7:0]  thr;
        logic        ack;
        logic [31:0] vec;
        logic [4:0]  id;
        logic [7:0]  cnt;
        logic        bsy;
    } vec_t;

    irq_coalesce_arbiter #(
        .NUM_SRC    (8),
        .CNT_W      (8),
        .TMR_W      (16),
        .HOLDOFF_CYC(4),
        .ACK_TO_CYC (16)
    ) dut (
        .clk            (clk),
        .srst           (srst),
        .src_event      (src_event),
        .cfg_enable     (cfg_enable),
        .cfg_threshold  (cfg_threshold),
        .cfg_timeout    (cfg_timeout),
        .irq_ack        (irq_ack),
        .irq_vector     (irq_vector),
        .irq_src_id     (irq_src_id),
        .irq_event_count(irq_event_count),
        .busy           (busy),
        .ack_timeout_err(ack_timeout_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [7:0] ev, input logic [7:0] thr, input logic ack,
                                input logic [31:0] vec, input logic [4:0] id,
                                input logic [7:0] cnt, input logic bsy);
        vec_t v;
        v.ev = ev; v.thr = thr; v.ack = ack; v.vec = vec; v.id = id; v.cnt = cnt; v.bsy = bsy;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_grant(input int limit, output int n, output bit found);
        n = 0;
        found = 1'b0;
        while (n < limit && !found) begin
            tick();
            n++;
            if (irq_vector != 32'h0) found = 1'b1;
        end
    endtask

    task automatic reset_dut();
        srst = 1'b1;
        src_event = '0;
        irq_ack = 1'b0;
        cfg_enable = 8'hFF;
        cfg_timeout = '0;
        tick();
        srst = 1'b0;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        vec_t tbl[23];
        int   n;
        bit   found;
        int   exp_rr[6];

        // ev, thr, ack -> vec, id, cnt, busy (sampled after the edge)
        tbl[0]  = mk(8'h04, 8'd3, 1'b0, 32'h0, 5'd0, 8'd0, 1'b0);
        tbl[1]  = mk(8'h04, 8'd3, 1'b0, 32'h0, 5'd0, 8'd0, 1'b0);
        tbl[2]  = mk(8'h04, 8'd3, 1'b0, 32'h0, 5'd0, 8'd0, 1'b0);
        tbl[3]  = mk(8'h00, 8'd3, 1'b0, 32'h4, 5'd2, 8'd3, 1'b1);
        tbl[4]  = mk(8'h02, 8'd3, 1'b0, 32'h4, 5'd2, 8'd3, 1'b1);
        tbl[5]  = mk(8'h00, 8'd3, 1'b1, 32'h0, 5'd0, 8'd0, 1'b1);
        tbl[6]  = mk(8'h00, 8'd3, 1'b0, 32'h0, 5'd0, 8'd0, 1'b1);
        tbl[7]  = mk(8'h00, 8'd3, 1'b0, 32'h0, 5'd0, 8'd0, 1'b1);
        tbl[8]  = mk(8'h00, 8'd3, 1'b0, 32'h0, 5'd0, 8'd0, 1'b1);
        tbl[9]  = mk(8'h00, 8'd3, 1'b0, 32'h0, 5'd0, 8'd0, 1'b0);
        tbl[10] = mk(8'h00, 8'd1, 1'b0, 32'h2, 5'd1, 8'd1, 1'b1);
        tbl[11] = mk(8'h00, 8'd1, 1'b1, 32'h0, 5'd0, 8'd0, 1'b1);
        tbl[12] = mk(8'h02, 8'd1, 1'b0, 32'h0, 5'd0, 8'd0, 1'b1);
        tbl[13] = mk(8'h00, 8'd1, 1'b0, 32'h0, 5'd0, 8'd0, 1'b1);
        tbl[14] = mk(8'h00, 8'd1, 1'b1, 32'h0, 5'd0, 8'd0, 1'b1);
        tbl[15] = mk(8'h00, 8'd1, 1'b0, 32'h0, 5'd0, 8'd0, 1'b0);
        tbl[16] = mk(8'h02, 8'd1, 1'b0, 32'h2, 5'd1, 8'd1, 1'b1);
        tbl[17] = mk(8'h00, 8'd1, 1'b1, 32'h0, 5'd0, 8'd0, 1'b1);
        tbl[18] = mk(8'h00, 8'd1, 1'b0, 32'h0, 5'd0, 8'd0, 1'b1);
        tbl[19] = mk(8'h00, 8'd1, 1'b0, 32'h0, 5'd0, 8'd0, 1'b1);
        tbl[20] = mk(8'h00, 8'd1, 1'b0, 32'h0, 5'd0, 8'd0, 1'b1);
        tbl[21] = mk(8'h00, 8'd1, 1'b0, 32'h0, 5'd0, 8'd0, 1'b0);
        tbl[22] = mk(8'h00, 8'd1, 1'b0, 32'h2, 5'd1, 8'd1, 1'b1);

        exp_rr[0] = 0; exp_rr[1] = 3; exp_rr[2] = 7;
        exp_rr[3] = 0; exp_rr[4] = 3; exp_rr[5] = 7;

        srst = 1'b1;
        src_event = '0;
        cfg_enable = 8'hFF;
        cfg_threshold = 8'd3;
        cfg_timeout = '0;
        irq_ack = 1'b0;
        tick();
        tick();
        chk("rst_vec", irq_vector, 32'h0);
        chk("rst_id", 32'(irq_src_id), 32'h0);
        chk("rst_cnt", 32'(irq_event_count), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(ack_timeout_err), 32'h0);
        srst = 1'b0;

        for (int r = 0; r < 23; r++) begin
            src_event = tbl[r].ev;
            cfg_threshold = tbl[r].thr;
            irq_ack = tbl[r].ack;
            tick();
            chk($sformatf("row%0d_vec", r), irq_vector, tbl[r].vec);
            chk($sformatf("row%0d_id", r), 32'(irq_src_id), 32'(tbl[r].id));
            chk($sformatf("row%0d_cnt", r), 32'(irq_event_count), 32'(tbl[r].cnt));
            chk($sformatf("row%0d_busy", r), 32'(busy), 32'(tbl[r].bsy));
        end
        src_event = '0;
        irq_ack = 1'b0;

        // Age timeout: single event on src 5, grant 21 edges later.
        reset_dut();
        cfg_threshold = 8'd10;
        cfg_timeout = 16'd20;
        src_event = 8'h20;
        tick();
        src_event = '0;
        wait_grant(40, n, found);
        chk("to_found", 32'(found), 32'h1);
        chk("to_latency", 32'(n), 32'd21);
        chk("to_id", 32'(irq_src_id), 32'd5);
        chk("to_cnt", 32'(irq_event_count), 32'd1);
        chk("to_busy", 32'(busy), 32'h1);
        cfg_threshold = 8'd1;
        src_event = 8'h20;
        tick();
        src_event = '0;
        chk("to_hold_vec", irq_vector, 32'h20);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("to_ack_vec", irq_vector, 32'h0);
        wait_grant(20, n, found);
        chk("ho_found", 32'(found), 32'h1);
        chk("ho_latency", 32'(n), 32'd5);
        chk("ho_cnt", 32'(irq_event_count), 32'd1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;

        // Round-robin over continuously ready sources 0, 3, 7.
        reset_dut();
        cfg_threshold = 8'd1;
        src_event = 8'h89;
        for (int k = 0; k < 6; k++) begin
            wait_grant(12, n, found);
            chk($sformatf("rr%0d_found", k), 32'(found), 32'h1);
            chk($sformatf("rr%0d_id", k), 32'(irq_src_id), 32'(exp_rr[k]));
            irq_ack = 1'b1;
            tick();
            irq_ack = 1'b0;
        end
        src_event = '0;

        // Saturation: src 4 accumulates 300 events while src 0 holds the grant.
        reset_dut();
        cfg_threshold = 8'd1;
        src_event = 8'h01;
        tick();
        src_event = '0;
        wait_grant(5, n, found);
        chk("sat_g0_id", 32'(irq_src_id), 32'd0);
        cfg_threshold = 8'd255;
        src_event = 8'h10;
        repeat (300) tick();
        src_event = '0;
        chk("sat_held_vec", irq_vector, 32'h1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        wait_grant(10, n, found);
        chk("sat_found", 32'(found), 32'h1);
        chk("sat_id", 32'(irq_src_id), 32'd4);
        chk("sat_cnt", 32'(irq_event_count), 32'd255);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        repeat (6) tick();
        chk("sat_idle_busy", 32'(busy), 32'h0);

        // Disable clears the pending count and discards events.
        src_event = 8'h10;
        repeat (5) tick();
        cfg_enable = 8'hEF;
        cfg_threshold = 8'd1;
        repeat (3) begin
            tick();
            chk("dis_no_grant", irq_vector, 32'h0);
        end
        src_event = '0;
        cfg_enable = 8'hFF;
        repeat (8) tick();
        chk("reen_no_grant", irq_vector, 32'h0);
        src_event = 8'h10;
        tick();
        src_event = '0;
        wait_grant(4, n, found);
        chk("reen_found", 32'(found), 32'h1);
        chk("reen_id", 32'(irq_src_id), 32'd4);
        chk("reen_cnt", 32'(irq_event_count), 32'd1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;

        // Unacknowledged grant, then reset mid-handshake.
        reset_dut();
        cfg_threshold = 8'd1;
        src_event = 8'h40;
        tick();
        src_event = '0;
        wait_grant(5, n, found);
        chk("wd_grant_id", 32'(irq_src_id), 32'd6);
`ifdef IRQ_COAL_ACK_WDOG_EN
        n = 0;
        while (n < 40 && irq_vector != 32'h0) begin
            tick();
            n++;
        end
        chk("wd_latency", 32'(n), 32'd16);
        chk("wd_vec", irq_vector, 32'h0);
        chk("wd_err", 32'(ack_timeout_err), 32'h1);
        chk("wd_busy", 32'(busy), 32'h1);
`else
        repeat (40) tick();
        chk("nowd_vec", irq_vector, 32'h40);
        chk("nowd_err", 32'(ack_timeout_err), 32'h0);
        chk("nowd_busy", 32'(busy), 32'h1);
`endif
        cfg_threshold = 8'd255;
        src_event = 8'h04;
        tick();
        src_event = '0;
        srst = 1'b1;
        tick();
        chk("srst_vec", irq_vector, 32'h0);
        chk("srst_id", 32'(irq_src_id), 32'h0);
        chk("srst_cnt", 32'(irq_event_count), 32'h0);
        chk("srst_busy", 32'(busy), 32'h0);
        chk("srst_err", 32'(ack_timeout_err), 32'h0);
        srst = 1'b0;
        cfg_threshold = 8'd1;
        repeat (5) tick();
        chk("srst_pending_lost", irq_vector, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_coalesce_arbiter.md
Name: irq_coalesce_arbiter

Overview:
- Front-end scheduler for the interrupt controller's `interrupt_vector` input.
- Collects single-cycle event pulses from up to NUM_SRC requesters (DMA, FFT, mailbox) and keeps a per-source pending count.
- Coalesces events by count threshold or age timeout.
- Grants one source at a time, round-robin, as a one-hot bit on `irq_vector`. Holds the bit until the processor acknowledges it via the interrupt-clear path.

Parameters:
- NUM_SRC, 8, number of event sources; legal range 1..32.
- CNT_W, 8, width of the per-source pending counter; saturating.
- TMR_W, 16, width of the per-source age timer and of `cfg_timeout`.
- HOLDOFF_CYC, 4, idle gap in cycles after each ack before the next grant; 0 is legal.
- ACK_TO_CYC, 1024, ack watchdog limit in cycles; used only with IRQ_COAL_ACK_WDOG_EN.

Ports:
- clk  in  1  clock; single clock domain.
- srst  in  1  synchronous active-high reset.
- src_event  in  NUM_SRC  per-source event pulse; each high cycle counts as one event.
- cfg_enable  in  NUM_SRC  per-source enable.
- cfg_threshold  in  CNT_W  event count that triggers a grant; 0 is treated as 1.
- cfg_timeout  in  TMR_W  age limit in cycles; 0 disables the timeout trigger.
- irq_ack  in  1  acknowledge pulse, wired from `interrupt_clear`.
- irq_vector  out  32  one-hot granted source, wired to the interrupt controller's `interrupt_vector`.
- irq_src_id  out  5  index of the granted source.
- irq_event_count  out  CNT_W  pending count snapshot taken at grant.
- busy  out  1  high in WAIT_ACK or HOLDOFF.
- ack_timeout_err  out  1  sticky watchdog error flag.

Behaviour:
- Reset:
  - All outputs 0; all counters and timers 0.
  - State IDLE; round-robin pointer at NUM_SRC-1, so source 0 has first priority.
- Pending counter, per source:
  - next = sat(cnt + src_event − (granted this cycle ? cnt : 0)).
  - A grant and an event in the same cycle leave cnt = 1.
  - Saturation holds at 2^CNT_W−1; further events are dropped.
- Disabled source:
  - cnt and age forced to 0; events discarded.
  - Disabling a source while it is granted does not end the handshake.
- Age timer, per source:
  - Cleared while cnt = 0 and on grant.
  - Otherwise increments each cycle, saturating.
- ready[i] = cfg_enable[i] && cnt[i] ≠ 0 && (cnt[i] ≥ max(cfg_threshold,1) || (cfg_timeout ≠ 0 && age[i] ≥ cfg_timeout)).
- State machine:
  - IDLE: if any ready, select the first ready index after the pointer, wrapping modulo NUM_SRC, and register the grant. Next cycle: `irq_vector` = one-hot of the selected index, `irq_src_id`/`irq_event_count` valid, pointer = selected index, state WAIT_ACK. Grant latency is 1 cycle from ready.
  - WAIT_ACK: outputs held stable. On `irq_ack`, the next cycle has `irq_vector`, `irq_src_id` and `irq_event_count` = 0. State then goes to HOLDOFF, or directly to IDLE if HOLDOFF_CYC = 0.
  - HOLDOFF: counts HOLDOFF_CYC cycles with no grant, then IDLE. Events keep accumulating throughout.
- `irq_ack` outside WAIT_ACK is ignored.
- Bits of `irq_vector` at NUM_SRC and above are always 0.
- Config inputs are sampled every cycle with no shadowing. Changing `cfg_threshold` mid-run affects only future ready evaluation.
- `srst` mid-handshake returns everything to reset state immediately; pending counts are lost.

Optional Feature:
- IRQ_COAL_ACK_WDOG_EN defined:
  - A WAIT_ACK cycle counter runs from grant.
  - If `irq_ack` has not arrived after ACK_TO_CYC cycles, `irq_vector` is dropped, `ack_timeout_err` is set, and the state goes to HOLDOFF.
  - The snapshot count is discarded, not restored.
  - `ack_timeout_err` clears only on `srst`.
  - An ack in the same cycle as the timeout wins: normal path, no error.
- Undefined: WAIT_ACK waits indefinitely; `ack_timeout_err` is tied to 0; no watchdog logic is synthesized.

Test Plan:
- Threshold trigger: NUM_SRC=8, threshold=3, timeout=0, 3 pulses on src 2 → `irq_vector`=0x04 one cycle after the 3rd event; `irq_event_count`=3; `busy`=1.
- Timeout trigger: threshold=10, timeout=20, 1 event on src 5 → grant at age 20 (+1 cycle); `irq_event_count`=1; ack → `irq_vector`=0 next cycle; next grant no earlier than HOLDOFF_CYC=4 cycles later.
- Round-robin fairness: threshold=1, srcs 0, 3 and 7 held continuously ready, ack each grant → grant order 0, 3, 7, 0, 3, …
- Grant/event collision: src 1 event coincident with the grant cycle → granted count excludes it; cnt[1]=1 afterward; ack plus holdoff → regrant with count 1 (threshold=1).
- Saturation and disable: 300 events on src 4 with CNT_W=8 and src disabled before threshold=255 … reaches 255 → count saturates at 255; `cfg_enable[4]`=0 clears cnt, and no grant occurs until re-enabled with new events.
- Watchdog (macro on, ACK_TO_CYC=16): grant, no ack → `irq_vector`=0 and `ack_timeout_err`=1 after 16 cycles; `srst` → `ack_timeout_err`=0 and all outputs 0 next cycle.
